// File: rtl/ifm_addr_gen_strided_if.sv
// Purpose : address stream from the IFM address generator to the IFM buffer read port.
// Ports   : addr_valid/addr_ready handshake; ifm_addr, read_len, last_in_tile (and pad_zero
//           when IFM_ADDR_GEN_PAD_EN is defined) travel with addr_valid.
// Modports: master = generator side, slave = consumer side.
interface ifm_addr_gen_strided_if #(
  parameter int ADDR_W = 20
);
  logic              addr_valid;
  logic              addr_ready;
  logic [ADDR_W-1:0] ifm_addr;
  logic [4:0]        read_len;
  logic              last_in_tile;
`ifdef IFM_ADDR_GEN_PAD_EN
  logic              pad_zero;

  modport master (output addr_valid, ifm_addr, read_len, last_in_tile, pad_zero, input addr_ready);
  modport slave  (input addr_valid, ifm_addr, read_len, last_in_tile, pad_zero, output addr_ready);
`else
  modport master (output addr_valid, ifm_addr, read_len, last_in_tile, input addr_ready);
  modport slave  (input addr_valid, ifm_addr, read_len, last_in_tile, output addr_ready);
`endif
endinterface

// File: rtl/ifm_addr_gen_strided.sv
// Purpose : walks the OFM in tiles (1 row x up to SYSTOLIC_SIZE columns) and emits one
//           IFM window-start address per (channel, ky, kx) for each tile.
// Ports   : start + cfg_* begin a layer; addr_if (master) carries the address stream;
//           tile_done / done are one-cycle pulses, busy spans SETUP..TILE_END.
// Latency : first address 2 cycles after start, then one beat per accepted handshake,
//           one bubble cycle per tile. Holds all outputs stable while addr_ready is low.
// Option  : IFM_ADDR_GEN_PAD_EN adds cfg_pad / pad_zero for top/left zero padding.
module ifm_addr_gen_strided #(
  parameter int SYSTOLIC_SIZE = 16,
  parameter int IFM_RAM_SIZE  = 705600,
  parameter int ADDR_W        = $clog2(IFM_RAM_SIZE),
  parameter int DIM_W         = 9,
  parameter int CH_W          = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [DIM_W-1:0] cfg_ifm_size,
  input  logic [CH_W-1:0]  cfg_ifm_channel,
  input  logic [3:0]       cfg_kernel_size,
  input  logic [1:0]       cfg_stride,
  input  logic [DIM_W-1:0] cfg_ofm_size,
`ifdef IFM_ADDR_GEN_PAD_EN
  input  logic [1:0]       cfg_pad,
`endif
  ifm_addr_gen_strided_if.master addr_if,
  output logic             tile_done,
  output logic             busy,
  output logic             done
);
  localparam int DW1 = DIM_W + 1;
  localparam logic [DW1-1:0] SYS_D = DW1'(SYSTOLIC_SIZE);

  typedef enum logic [2:0] {IDLE, SETUP, RUN, TILE_END, DONE} state_t;
  state_t state;

  logic [DIM_W-1:0]  h_r, o_r;
  logic [CH_W-1:0]   c_r;
  logic [3:0]        k_r;
  logic [1:0]        s_r;
  logic [ADDR_W-1:0] hh_r, tile_step_r, row_step_r;
  logic [DIM_W-1:0]  oy, ox_base;
  logic [CH_W-1:0]   ch;
  logic [3:0]        ky, kx;
  // Origins nest: row (oy) -> tile (ox_base) -> channel -> kernel line -> address.
  logic [ADDR_W-1:0] row_org, tile_org, chan_org, line_org, addr_r;
  logic [4:0]        read_len_r;

  logic              kx_last, ky_last, ch_last, col_wrap, last_tile, pad_c;
  logic [DW1-1:0]    nx;
  logic [ADDR_W-1:0] h_a, next_org, org0;

  function automatic logic [4:0] tile_len(input logic [DIM_W-1:0] o, input logic [DIM_W-1:0] oxb);
    logic [DW1-1:0] rem;
    rem = DW1'(o) - DW1'(oxb);
    return (rem >= SYS_D) ? 5'(SYS_D) : 5'(rem);
  endfunction

`ifdef IFM_ADDR_GEN_PAD_EN
  localparam int CW = DIM_W + 2;
  localparam int SW = DIM_W + 4;
  logic [1:0]    p_r;
  logic [CW-1:0] oy_s, ox_s;  // oy*S and ox_base*S, tracked incrementally
  logic [SW-1:0] iy, ix;

  always_comb begin
    iy    = SW'(oy_s) + SW'(ky) - SW'(p_r);
    ix    = SW'(ox_s) + SW'(kx) - SW'(p_r);
    // A negative iy also fails the unsigned >= H test; right edge is left to read_len.
    pad_c = iy[SW-1] | ix[SW-1] | (iy >= SW'(h_r));
  end
  // Shifting every origin by -(P*H + P) makes the linear walk land on iy*H + ix directly.
  assign org0 = ADDR_W'(0) - (ADDR_W'(p_r) * ADDR_W'(h_r) + ADDR_W'(p_r));
  assign addr_if.pad_zero = (state == RUN) & pad_c;
`else
  assign pad_c = 1'b0;
  assign org0  = '0;
`endif

  assign h_a       = ADDR_W'(h_r);
  assign kx_last   = (kx == k_r - 4'd1);
  assign ky_last   = (ky == k_r - 4'd1);
  assign ch_last   = (ch == c_r - CH_W'(1));
  assign nx        = DW1'(ox_base) + SYS_D;
  assign col_wrap  = (nx >= DW1'(o_r));
  assign last_tile = col_wrap && (oy == o_r - DIM_W'(1));
  assign next_org  = col_wrap ? row_org + row_step_r : tile_org + tile_step_r;

  assign addr_if.addr_valid   = (state == RUN);
  assign addr_if.ifm_addr     = pad_c ? '0 : addr_r;
  assign addr_if.read_len     = read_len_r;
  assign addr_if.last_in_tile = (state == RUN) && kx_last && ky_last && ch_last;
  assign tile_done            = (state == TILE_END);
  assign done                 = (state == DONE);
  assign busy                 = (state == SETUP) || (state == RUN) || (state == TILE_END);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      h_r <= '0; o_r <= '0; c_r <= '0; k_r <= '0; s_r <= '0;
      hh_r <= '0; tile_step_r <= '0; row_step_r <= '0;
      oy <= '0; ox_base <= '0; ch <= '0; ky <= '0; kx <= '0;
      row_org <= '0; tile_org <= '0; chan_org <= '0; line_org <= '0; addr_r <= '0;
      read_len_r <= '0;
`ifdef IFM_ADDR_GEN_PAD_EN
      p_r <= '0; oy_s <= '0; ox_s <= '0;
`endif
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            h_r   <= cfg_ifm_size;
            o_r   <= cfg_ofm_size;
            c_r   <= cfg_ifm_channel;
            k_r   <= cfg_kernel_size;
            s_r   <= (cfg_stride == 2'd0) ? 2'd1 : cfg_stride;
`ifdef IFM_ADDR_GEN_PAD_EN
            p_r   <= cfg_pad;
`endif
            state <= SETUP;
          end else begin
            state <= IDLE;
          end
        end
        SETUP: begin
          // The only multiplies: per-layer constants, off the per-beat path.
          hh_r        <= h_a * h_a;
          tile_step_r <= ADDR_W'(SYSTOLIC_SIZE) * ADDR_W'(s_r);
          row_step_r  <= h_a * ADDR_W'(s_r);
          oy <= '0; ox_base <= '0; ch <= '0; ky <= '0; kx <= '0;
          row_org <= org0; tile_org <= org0; chan_org <= org0; line_org <= org0; addr_r <= org0;
          read_len_r  <= tile_len(o_r, '0);
`ifdef IFM_ADDR_GEN_PAD_EN
          oy_s <= '0; ox_s <= '0;
`endif
          state <= RUN;
        end
        RUN: begin
          if (addr_if.addr_ready) begin
            if (!kx_last) begin
              kx     <= kx + 4'd1;
              addr_r <= addr_r + ADDR_W'(1);
            end else begin
              kx <= '0;
              if (!ky_last) begin
                ky       <= ky + 4'd1;
                line_org <= line_org + h_a;
                addr_r   <= line_org + h_a;
              end else begin
                ky <= '0;
                if (!ch_last) begin
                  ch       <= ch + CH_W'(1);
                  chan_org <= chan_org + hh_r;
                  line_org <= chan_org + hh_r;
                  addr_r   <= chan_org + hh_r;
                end else begin
                  ch    <= '0;
                  state <= TILE_END;
                end
              end
            end
          end
        end
        TILE_END: begin
          if (last_tile) begin
            state <= DONE;
          end else begin
            state    <= RUN;
            tile_org <= next_org;
            chan_org <= next_org;
            line_org <= next_org;
            addr_r   <= next_org;
            ch <= '0; ky <= '0; kx <= '0;
            if (col_wrap) begin
              ox_base    <= '0;
              oy         <= oy + DIM_W'(1);
              row_org    <= next_org;
              read_len_r <= tile_len(o_r, '0);
`ifdef IFM_ADDR_GEN_PAD_EN
              oy_s <= oy_s + CW'(s_r);
              ox_s <= '0;
`endif
            end else begin
              ox_base    <= nx[DIM_W-1:0];
              read_len_r <= tile_len(o_r, nx[DIM_W-1:0]);
`ifdef IFM_ADDR_GEN_PAD_EN
              ox_s <= ox_s + CW'(tile_step_r);
`endif
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ifm_addr_gen_strided.sv
// Bench for ifm_addr_gen_strided: directed layers plus random configurations, every
// accepted beat compared against a nested-loop model of the OFM/tile/kernel walk.
module tb_ifm_addr_gen_strided;
  localparam int SYS = 16;
  localparam int AW  = 20;
  localparam int DW  = 9;
  localparam int CW  = 11;
`ifdef IFM_ADDR_GEN_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [DW-1:0] cfg_ifm_size, cfg_ofm_size;
  logic [CW-1:0] cfg_ifm_channel;
  logic [3:0]    cfg_kernel_size;
  logic [1:0]    cfg_stride;
`ifdef IFM_ADDR_GEN_PAD_EN
  logic [1:0]    cfg_pad;
`endif
  logic          tile_done, busy, done;

  ifm_addr_gen_strided_if #(.ADDR_W(AW)) aif ();

  ifm_addr_gen_strided #(
    .SYSTOLIC_SIZE(SYS), .IFM_RAM_SIZE(705600), .ADDR_W(AW), .DIM_W(DW), .CH_W(CW)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .cfg_ifm_size(cfg_ifm_size), .cfg_ifm_channel(cfg_ifm_channel),
    .cfg_kernel_size(cfg_kernel_size), .cfg_stride(cfg_stride), .cfg_ofm_size(cfg_ofm_size),
`ifdef IFM_ADDR_GEN_PAD_EN
    .cfg_pad(cfg_pad),
`endif
    .addr_if(aif), .tile_done(tile_done), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int addr;
    int rlen;
    bit last;
    bit pad;
  } beat_t;

  beat_t exp_q[$];
  int    n_tiles;
  int    errors = 0;
  int    checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference walk: for each output row, each column tile, every (ch, ky, kx).
  task automatic build_model(input int h, input int c, input int k, input int s,
                             input int o, input int p);
    int se, rl, iy, ix;
    beat_t b;
    exp_q.delete();
    n_tiles = 0;
    se = (s == 0) ? 1 : s;
    for (int oy = 0; oy < o; oy++) begin
      for (int oxb = 0; oxb < o; oxb += SYS) begin
        n_tiles++;
        rl = (o - oxb < SYS) ? o - oxb : SYS;
        for (int ch = 0; ch < c; ch++)
          for (int ky = 0; ky < k; ky++)
            for (int kx = 0; kx < k; kx++) begin
              iy     = oy * se + ky - p;
              ix     = oxb * se + kx - p;
              b.rlen = rl;
              b.last = (ch == c - 1) && (ky == k - 1) && (kx == k - 1);
              b.pad  = PAD_EN && (iy < 0 || iy >= h || ix < 0);
              b.addr = b.pad ? 0 : ((ch * h * h + iy * h + ix) & ((1 << AW) - 1));
              exp_q.push_back(b);
            end
      end
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_valid"}, aif.addr_valid, 0);
    check({tag, "_addr"}, aif.ifm_addr, 0);
    check({tag, "_read_len"}, aif.read_len, 0);
    check({tag, "_last"}, aif.last_in_tile, 0);
    check({tag, "_tile_done"}, tile_done, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
  endtask

  // mode: 0 = ready always high, 1 = random ready, 2 = ready low 3 cycles on beat index 3.
  // abort_at >= 0: assert reset right after that many beats have been accepted.
  task automatic run_layer(input int h, input int c, input int k, input int s, input int o,
                           input int p, input int mode, input int abort_at, input bit inject);
    int  idx, n, tiles, first_n, hold, budget, pe;
    bit  fin, pend_tile, prev_stall, r, acc;
    pe = PAD_EN ? p : 0;
    build_model(h, c, k, s, o, pe);
    budget = (exp_q.size() + n_tiles) * 6 + 20;
    @(negedge clk);
    cfg_ifm_size    = DW'(h);
    cfg_ifm_channel = CW'(c);
    cfg_kernel_size = 4'(k);
    cfg_stride      = 2'(s);
    cfg_ofm_size    = DW'(o);
`ifdef IFM_ADDR_GEN_PAD_EN
    cfg_pad         = 2'(pe);
`endif
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    idx = 0; n = 1; tiles = 0; first_n = -1; hold = 0;
    fin = 0; pend_tile = 0; prev_stall = 0;
    while (!fin && n < budget) begin
      start = (inject && n == 6);
      if (inject && n == 6) begin
        cfg_ifm_size    = DW'(17);
        cfg_ifm_channel = CW'(5);
      end
      if (done) begin
        check("done_beats", idx, exp_q.size());
        check("done_tiles", tiles, n_tiles);
        check("busy_at_done", busy, 0);
        if (mode == 0) check("done_cycle", n, 2 + n_tiles * (c * k * k + 1));
        fin = 1;
      end else begin
        check("busy", busy, 1);
        check("tile_done", tile_done, pend_tile);
        if (tile_done) tiles++;
        if (prev_stall) check("valid_held", aif.addr_valid, 1);
        if (aif.addr_valid) begin
          if (first_n < 0) begin
            first_n = n;
            check("first_valid_cycle", n, 2);
          end
          if (idx >= exp_q.size()) begin
            check("beat_count", idx, exp_q.size() - 1);
            fin = 1;
          end else begin
            check($sformatf("addr[%0d]", idx), aif.ifm_addr, exp_q[idx].addr);
            check($sformatf("read_len[%0d]", idx), aif.read_len, exp_q[idx].rlen);
            check($sformatf("last[%0d]", idx), aif.last_in_tile, exp_q[idx].last);
`ifdef IFM_ADDR_GEN_PAD_EN
            check($sformatf("pad_zero[%0d]", idx), aif.pad_zero, exp_q[idx].pad);
`endif
          end
        end
      end
      if (!fin) begin
        case (mode)
          0:       r = 1'b1;
          1:       r = ($urandom_range(0, 3) != 0);
          default: r = !(idx == 3 && hold < 3);
        endcase
        if (!r && aif.addr_valid) hold++;
        aif.addr_ready = r;
        acc        = aif.addr_valid && r;
        prev_stall = aif.addr_valid && !r;
        pend_tile  = acc && exp_q[idx].last;
        if (acc) idx++;
        if (acc && abort_at >= 0 && idx == abort_at) begin
          @(posedge clk);
          #1 rst_n = 1'b0;
          #1 check_idle_outputs("mid_reset");
          aif.addr_ready = 1'b0;
          start = 1'b0;
          @(negedge clk);
          rst_n = 1'b1;
          return;
        end
        @(negedge clk);
        n++;
      end
    end
    start = 1'b0;
    check("layer_finished", fin, 1);
    @(negedge clk);
    check("done_pulse", done, 0);
    check("valid_after_done", aif.addr_valid, 0);
    aif.addr_ready = 1'b0;
  endtask

  initial begin
    int h, c, k, s, o, p;
    rst_n = 1'b0; start = 1'b0; aif.addr_ready = 1'b0;
    cfg_ifm_size = '0; cfg_ifm_channel = '0; cfg_kernel_size = '0;
    cfg_stride = '0; cfg_ofm_size = '0;
`ifdef IFM_ADDR_GEN_PAD_EN
    cfg_pad = '0;
`endif
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1'b1;

    run_layer(5, 1, 3, 1, 3, 0, 0, -1, 1'b0);   // 3 tiles of 9 beats
    run_layer(7, 2, 3, 2, 3, 0, 1, -1, 1'b1);   // stride 2, start pulse while busy
    run_layer(20, 2, 1, 1, 20, 0, 0, -1, 1'b0); // two column tiles per row, read_len 16/4
    run_layer(5, 1, 3, 1, 3, 0, 2, -1, 1'b0);   // stall on beat index 3
    run_layer(5, 1, 3, 1, 3, 0, 0, 10, 1'b0);   // reset mid-layer
    run_layer(5, 1, 3, 1, 3, 0, 0, -1, 1'b0);   // clean re-run after reset
    run_layer(6, 1, 2, 0, 5, 0, 1, -1, 1'b0);   // stride 0 behaves as 1
`ifdef IFM_ADDR_GEN_PAD_EN
    run_layer(4, 1, 3, 1, 4, 1, 1, -1, 1'b0);   // top/left padding
`endif
    for (int i = 0; i < 6; i++) begin
      h = $urandom_range(3, 12);
      c = $urandom_range(1, 3);
      k = $urandom_range(1, 4);
      s = $urandom_range(0, 3);
      o = $urandom_range(1, 20);
      p = $urandom_range(0, 3);
      run_layer(h, c, k, s, o, p, 1, -1, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
